lsf_input_sequencer: RTL and testbench
======================================

# lsf_input_sequencer

Multi-channel input stage for the Legendre segment finder. Buffers MDT hits and ROIs from `NCH` hit-extraction channels in real synchronous FIFOs, which replace the spy-buffer stand-ins. Frames each channel's hits into complete events using the end-of-frame pulse. Round-robins whole events, ROI first, then hits, then an eof strobe, into a single `legendreEngine_2clk` input port, with overflow protection and drop counters.

## Interface
- `NCH`, 4: number of input channels.
- `HIT_W`, `HEG2SFHIT_LEN`: hit word width.
- `ROI_W`, `HEG2SFSLC_LEN`: ROI word width.
- `HIT_DEPTH`, 32: hit FIFO entries per channel; power of two, ≥4.
- `ROI_DEPTH`, 4: ROI FIFO entries per channel; power of two, ≥2.
- `AF_MARGIN`, 4: `o_hit_af` asserts when occupancy ≥ `HIT_DEPTH-AF_MARGIN`.
- `MAX_HITS`, 16: hits forwarded per event; any excess is truncated.
- `clock`  in  1  single clock.
- `reset`  in  1  synchronous, active-high.
- `mdt_hit`  in  NCH×HIT_W  hit data per channel.
- `mdt_hit_we`  in  NCH  hit write strobe.
- `roi`  in  NCH×ROI_W  ROI data per channel.
- `roi_we`  in  NCH  ROI write strobe.
- `i_eof`  in  NCH  end-of-event pulse per channel.
- `i_engine_ready`  in  1  engine can accept a new event.
- `o_hit_af`  out  NCH  hit FIFO almost full.
- `o_roi`  out  ROI_W  ROI to engine.
- `o_roi_vld`  out  1  ROI valid; exactly one cycle per event.
- `o_hit`  out  HIT_W  hit to engine.
- `o_hit_vld`  out  1  hit valid.
- `o_eof`  out  1  one-cycle end-of-event strobe.
- `o_ch`  out  clog2(NCH)  channel currently served; held for the whole event.
- `o_hit_drop_cnt`  out  NCH×16  dropped plus truncated hits; saturates at 0xFFFF.
- `o_roi_drop_cnt`  out  NCH×16  dropped ROIs; saturates at 0xFFFF.

## Operation
- **Hit FIFO entry format:** each entry is `{last, is_marker, hit}`. The FIFO is first-word-fall-through: the head is visible while the FIFO is not empty, and a pop consumes it.
- **Write: `mdt_hit_we` only.** The hit is accepted if occupancy < `HIT_DEPTH-1`. Otherwise it is dropped and the hit drop counter increments.
- **Write: `i_eof` only.** A marker entry (`is_marker=1`) is written. The marker always fits because one slot is reserved for it.
- **Write: `mdt_hit_we` and `i_eof` in the same cycle.** If there is room, a single hit entry is written with `last=1`. If there is no room, the hit is dropped and counted, and a marker is written instead.
- **Event count:** the per-channel count increments on every `last` or marker write and decrements when the sequencer starts that channel. A simultaneous increment and decrement leaves it unchanged. Width is clog2(HIT_DEPTH+1).
- **ROI FIFO:** a write when full drops the ROI and increments the ROI drop counter. Fullness is evaluated before a same-cycle pop.
- **Eligible channel:** event count > 0 and ROI FIFO not empty.
- **FSM states:** IDLE, HITS.
- **IDLE:**
  - If `i_engine_ready=1` and at least one channel is eligible, pick the first eligible channel after the last one served, modulo NCH.
  - Pop its ROI, latch `o_ch`, clear the event hit counter, go to HITS.
- **HITS:** pop one head entry per cycle.
  - A hit with counter < `MAX_HITS` is forwarded and the counter increments.
  - A hit with counter ≥ `MAX_HITS` is not forwarded and the drop counter increments.
  - A marker, or a hit with `last=1`, ends the event: `o_eof` follows it, and the state returns to IDLE. A `last` hit under the cap is forwarded in the same cycle as `o_eof`.
- **Empty FIFO in HITS:** cannot occur, because eligibility guarantees the terminator is already stored.
- **Event without hits:** produces an ROI followed by an eof.

## Timing
- **Output registers:** all `o_*` data and strobes are registered and appear one cycle after the pop.
- **Reset:** every output and counter is 0, FIFOs are flushed, the FSM is in IDLE, and the round-robin pointer sits so channel 0 is served first.
- **Event latency:** hit written at t, `i_eof` at t+1. Event count is nonzero at t+2, ROI pop at t+2, `o_roi_vld` at t+3, `o_hit_vld` at t+4, `o_eof` at t+5.
- **Throughput:** one hit per cycle inside an event, with at least one IDLE cycle between events.
- **`i_engine_ready`:** sampled only in IDLE. Deasserting it mid-event has no effect.
- **`o_hit_af`:** combinational on occupancy, updates the cycle after the write.
- **Reset mid-event:** no `o_eof` is issued for the interrupted event. All outputs are 0 from the cycle after `reset` is sampled high.

## Structure
- Widths come from the shared `l0mdt_dataformats_svh` package. Add an `lsf_hit_entry_t` packed struct there.
- Sub-module `lsf_sync_fifo #(WIDTH, DEPTH)`:
  - FWFT, one clock.
  - Ports: count, full, empty.
  - Instantiated 2×NCH times.
- The arbiter, FSM and counters stay in the top module.

## Test plan
- **Single event:** ch0 hits 0xA, 0xB, eof, then ROI 0x5. Expect `o_roi=0x5`, hits 0xA then 0xB, eof, `o_ch=0`, same latency as above.
- **Round robin:** complete events queued on all 4 channels in the same cycle. Expect service order 0,1,2,3; then ch1 and ch3 re-queued are served in order 1,3.
- **Overflow:** 40 hits to ch2 with depth 32, then eof. Expect 31 hits stored, 9 drops counted, and the marker delivered. With `MAX_HITS=16`, expect 16 forwarded and a drop count of 24.
- **Hit and eof in the same cycle:** expect a single hit followed by `o_eof` in the same cycle. Eof alone with no hits gives ROI then eof, with no `o_hit_vld`.
- **Backpressure:** `i_engine_ready=0` with three events queued gives no output. ROI FIFO overflow on the 5th ROI increments the ROI drop counter to 1.
- **Reset:** reset asserted during HITS gives all outputs 0 the next cycle and counters at 0. A new event afterwards is served normally.

Source files
------------

// File: rtl/lsf_input_sequencer_pkg.sv
// Shared widths, hit-entry layout and FSM encoding for the LSF input sequencer.
package lsf_input_sequencer_pkg;

    localparam int HEG2SFHIT_LEN = 24;
    localparam int HEG2SFSLC_LEN = 32;

    typedef struct packed {
        logic                     last;
        logic                     is_marker;
        logic [HEG2SFHIT_LEN-1:0] hit;
    } lsf_hit_entry_t;

    typedef enum logic {
        IDLE = 1'b0,
        HITS = 1'b1
    } lsf_state_e;

    // Saturating add of a small increment to a 16-bit drop counter.
    function automatic logic [15:0] sat_add16(input logic [15:0] val, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, val} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

endpackage

// File: rtl/lsf_input_sequencer_if.sv
// Engine-side port of the sequencer: framed ROI/hit stream out, ready back in.
interface lsf_input_sequencer_if
    import lsf_input_sequencer_pkg::*;
#(
    parameter int HIT_W = HEG2SFHIT_LEN,
    parameter int ROI_W = HEG2SFSLC_LEN,
    parameter int CH_W  = 2
);
    logic [ROI_W-1:0] o_roi;
    logic             o_roi_vld;
    logic [HIT_W-1:0] o_hit;
    logic             o_hit_vld;
    logic             o_eof;
    logic [CH_W-1:0]  o_ch;
    logic             i_engine_ready;

    modport master (
        output o_roi, o_roi_vld, o_hit, o_hit_vld, o_eof, o_ch,
        input  i_engine_ready
    );

    modport slave (
        input  o_roi, o_roi_vld, o_hit, o_hit_vld, o_eof, o_ch,
        output i_engine_ready
    );
endinterface

// File: rtl/lsf_input_sequencer_fifo.sv
// Single-clock first-word-fall-through FIFO; writes while full are ignored.
module lsf_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       wr_en_i,
    input  logic [WIDTH-1:0]           wr_data_i,
    input  logic                       rd_en_i,
    output logic [WIDTH-1:0]           rd_data_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wrPtr_q;
    logic [AW-1:0]    rdPtr_q;
    logic [CW-1:0]    count_q;
    logic             doWrite;
    logic             doRead;

    assign full_o    = (count_q == CW'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign doWrite   = wr_en_i && !full_o;
    assign doRead    = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rdPtr_q];
    assign count_o   = count_q;

    // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
    always_ff @(posedge clock) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doWrite) wrPtr_q <= wrPtr_q + 1'b1;
            if (doRead)  rdPtr_q <= rdPtr_q + 1'b1;
            case ({doWrite, doRead})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since occupancy gates visibility.
    always_ff @(posedge clock) begin
        if (doWrite) mem_q[wrPtr_q] <= wr_data_i;
    end
endmodule

// File: rtl/lsf_input_sequencer.sv
// Multi-channel input stage: per-channel hit/ROI FIFOs, event framing and a
// round-robin event arbiter feeding one Legendre engine port.
module lsf_input_sequencer
    import lsf_input_sequencer_pkg::*;
#(
    parameter int NCH       = 4,
    parameter int HIT_W     = HEG2SFHIT_LEN,
    parameter int ROI_W     = HEG2SFSLC_LEN,
    parameter int HIT_DEPTH = 32,
    parameter int ROI_DEPTH = 4,
    parameter int AF_MARGIN = 4,
    parameter int MAX_HITS  = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NCH-1:0][HIT_W-1:0]  mdt_hit,
    input  logic [NCH-1:0]             mdt_hit_we,
    input  logic [NCH-1:0][ROI_W-1:0]  roi,
    input  logic [NCH-1:0]             roi_we,
    input  logic [NCH-1:0]             i_eof,
    output logic [NCH-1:0]             o_hit_af,
    output logic [NCH-1:0][15:0]       o_hit_drop_cnt,
    output logic [NCH-1:0][15:0]       o_roi_drop_cnt,
    lsf_input_sequencer_if.master      eng
);
    localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int HCW  = $clog2(HIT_DEPTH+1);
    localparam int RCW  = $clog2(ROI_DEPTH+1);
    localparam int NCW  = $clog2(MAX_HITS+1);

    typedef struct packed {
        logic             last;
        logic             is_marker;
        logic [HIT_W-1:0] hit;
    } entry_t;

    entry_t           hitHead [NCH];
    logic [ROI_W-1:0] roiHead [NCH];
    logic [NCH-1:0]   hitEmpty;
    logic [NCH-1:0]   eligible;
    entry_t           head;

    lsf_state_e       state_q,  state_d;
    logic [CH_W-1:0]  ch_q,     ch_d;
    logic [CH_W-1:0]  rr_q,     rr_d;
    logic [NCW-1:0]   nHits_q,  nHits_d;
    logic [ROI_W-1:0] roiOut_q, roiOut_d;
    logic [HIT_W-1:0] hitOut_q, hitOut_d;
    logic             roiVld_q, roiVld_d;
    logic             hitVld_q, hitVld_d;
    logic             eofOut_q, eofOut_d;
    logic             startEvt;
    logic             hitsPop;
    logic             truncDrop;
    logic             anyElig;
    logic [CH_W-1:0]  pick;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        entry_t         hitWrData;
        logic           hitWrEn;
        logic           hitWrDrop;
        logic           hitTermWr;
        logic           hitRoom;
        logic           hitFull;
        logic           roiFull;
        logic           roiEmpty;
        logic           evtDec;
        logic [1:0]     hitDropInc;
        logic [HCW-1:0] hitCount;
        logic [RCW-1:0] roiCount;
        logic [HCW-1:0] evtCnt_q;
        logic [15:0]    hitDrop_q;
        logic [15:0]    roiDrop_q;

        lsf_sync_fifo #(.WIDTH($bits(entry_t)), .DEPTH(HIT_DEPTH)) u_hit_fifo (
            .clock     (clock),
            .reset     (reset),
            .wr_en_i   (hitWrEn),
            .wr_data_i (hitWrData),
            .rd_en_i   (hitsPop && (ch_q == CH_W'(c))),
            .rd_data_o (hitHead[c]),
            .count_o   (hitCount),
            .full_o    (hitFull),
            .empty_o   (hitEmpty[c])
        );

        lsf_sync_fifo #(.WIDTH(ROI_W), .DEPTH(ROI_DEPTH)) u_roi_fifo (
            .clock     (clock),
            .reset     (reset),
            .wr_en_i   (roi_we[c]),
            .wr_data_i (roi[c]),
            .rd_en_i   (startEvt && (pick == CH_W'(c)) && !roiEmpty),
            .rd_data_o (roiHead[c]),
            .count_o   (roiCount),
            .full_o    (roiFull),
            .empty_o   (roiEmpty)
        );

        // One slot stays reserved for the terminator, so plain hits need two free.
        assign hitRoom     = (hitCount < HCW'(HIT_DEPTH-1));
        assign hitTermWr   = hitWrEn && !hitFull && (hitWrData.last || hitWrData.is_marker);
        assign evtDec      = startEvt && (pick == CH_W'(c));
        assign eligible[c] = (evtCnt_q != '0) && (roiCount != '0);
        assign hitDropInc  = {1'b0, hitWrDrop} + {1'b0, truncDrop && (ch_q == CH_W'(c))};

        assign o_hit_af[c]       = (hitCount >= HCW'(HIT_DEPTH-AF_MARGIN));
        assign o_hit_drop_cnt[c] = hitDrop_q;
        assign o_roi_drop_cnt[c] = roiDrop_q;

        // Turn hit/eof strobes into a single FIFO entry; a hit with eof folds into a last hit.
        always_comb begin
            hitWrEn   = 1'b0;
            hitWrDrop = 1'b0;
            hitWrData = '0;
            if (mdt_hit_we[c] && i_eof[c]) begin
                hitWrEn = 1'b1;
                if (hitRoom) begin
                    hitWrData.last = 1'b1;
                    hitWrData.hit  = mdt_hit[c];
                end else begin
                    hitWrData.is_marker = 1'b1;
                    hitWrDrop           = 1'b1;
                end
            end else if (mdt_hit_we[c]) begin
                hitWrEn       = hitRoom;
                hitWrDrop     = !hitRoom;
                hitWrData.hit = mdt_hit[c];
            end else if (i_eof[c]) begin
                hitWrEn             = 1'b1;
                hitWrData.is_marker = 1'b1;
            end
        end

        // Complete events stored per channel, plus saturating drop counters.
        always_ff @(posedge clock) begin
            if (reset) begin
                evtCnt_q  <= '0;
                hitDrop_q <= '0;
                roiDrop_q <= '0;
            end else begin
                case ({hitTermWr, evtDec})
                    2'b10:   evtCnt_q <= evtCnt_q + 1'b1;
                    2'b01:   evtCnt_q <= evtCnt_q - 1'b1;
                    default: evtCnt_q <= evtCnt_q;
                endcase
                hitDrop_q <= sat_add16(hitDrop_q, hitDropInc);
                roiDrop_q <= sat_add16(roiDrop_q, {1'b0, roi_we[c] && roiFull});
            end
        end
    end

    assign head = hitHead[ch_q];

    // Round-robin search starting just after the channel served last.
    always_comb begin
        logic [CH_W-1:0] idx;
        idx     = '0;
        pick    = rr_q;
        anyElig = 1'b0;
        for (int k = 1; k <= NCH; k++) begin
            idx = CH_W'((int'(rr_q) + k) % NCH);
            if (!anyElig && eligible[idx]) begin
                anyElig = 1'b1;
                pick    = idx;
            end
        end
    end

    // Event FSM: start an event in IDLE, then drain one entry per cycle in HITS.
    always_comb begin
        state_d   = state_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        nHits_d   = nHits_q;
        roiOut_d  = '0;
        roiVld_d  = 1'b0;
        hitOut_d  = '0;
        hitVld_d  = 1'b0;
        eofOut_d  = 1'b0;
        startEvt  = 1'b0;
        hitsPop   = 1'b0;
        truncDrop = 1'b0;
        case (state_q)
            IDLE: begin
                if (eng.i_engine_ready && anyElig) begin
                    startEvt = 1'b1;
                    roiOut_d = roiHead[pick];
                    roiVld_d = 1'b1;
                    ch_d     = pick;
                    rr_d     = pick;
                    nHits_d  = '0;
                    state_d  = HITS;
                end
            end
            HITS: begin
                if (!hitEmpty[ch_q]) begin
                    hitsPop = 1'b1;
                    if (head.is_marker) begin
                        eofOut_d = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        if (nHits_q < NCW'(MAX_HITS)) begin
                            hitOut_d = head.hit;
                            hitVld_d = 1'b1;
                            nHits_d  = nHits_q + 1'b1;
                        end else begin
                            truncDrop = 1'b1;
                        end
                        if (head.last) begin
                            eofOut_d = 1'b1;
                            state_d  = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; pointer resets to the last channel so channel 0 goes first.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            ch_q     <= '0;
            rr_q     <= CH_W'(NCH-1);
            nHits_q  <= '0;
            roiOut_q <= '0;
            roiVld_q <= 1'b0;
            hitOut_q <= '0;
            hitVld_q <= 1'b0;
            eofOut_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ch_q     <= ch_d;
            rr_q     <= rr_d;
            nHits_q  <= nHits_d;
            roiOut_q <= roiOut_d;
            roiVld_q <= roiVld_d;
            hitOut_q <= hitOut_d;
            hitVld_q <= hitVld_d;
            eofOut_q <= eofOut_d;
        end
    end

    assign eng.o_roi     = roiOut_q;
    assign eng.o_roi_vld = roiVld_q;
    assign eng.o_hit     = hitOut_q;
    assign eng.o_hit_vld = hitVld_q;
    assign eng.o_eof     = eofOut_q;
    assign eng.o_ch      = ch_q;
endmodule

// File: tb/tb_lsf_input_sequencer.sv
// Directed bench for lsf_input_sequencer: logs the engine stream and compares
// it against hand-computed event sequences.
module tb_lsf_input_sequencer;
    import lsf_input_sequencer_pkg::*;

    localparam int NCH   = 4;
    localparam int HIT_W = HEG2SFHIT_LEN;
    localparam int ROI_W = HEG2SFSLC_LEN;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NCH-1:0][HIT_W-1:0] mdt_hit;
    logic [NCH-1:0]            mdt_hit_we;
    logic [NCH-1:0][ROI_W-1:0] roi;
    logic [NCH-1:0]            roi_we;
    logic [NCH-1:0]            i_eof;
    logic [NCH-1:0]            o_hit_af;
    logic [NCH-1:0][15:0]      o_hit_drop_cnt;
    logic [NCH-1:0][15:0]      o_roi_drop_cnt;

    lsf_input_sequencer_if #(.HIT_W(HIT_W), .ROI_W(ROI_W), .CH_W(2)) eng ();

    lsf_input_sequencer #(
        .NCH(NCH), .HIT_W(HIT_W), .ROI_W(ROI_W), .HIT_DEPTH(32),
        .ROI_DEPTH(4), .AF_MARGIN(4), .MAX_HITS(16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .mdt_hit        (mdt_hit),
        .mdt_hit_we     (mdt_hit_we),
        .roi            (roi),
        .roi_we         (roi_we),
        .i_eof          (i_eof),
        .o_hit_af       (o_hit_af),
        .o_hit_drop_cnt (o_hit_drop_cnt),
        .o_roi_drop_cnt (o_roi_drop_cnt),
        .eng            (eng)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vecCount = 0;
    int errCount = 0;

    logic [39:0] logTok[$];
    int          logCyc[$];
    logic [39:0] lastTok;
    int          lastCyc;

    function automatic logic [39:0] mk(input logic [3:0] t, input logic [1:0] ch, input logic [31:0] d);
        return {t, 2'b00, ch, d};
    endfunction

    // Record every engine-side strobe with its channel and cycle.
    always @(negedge clock) begin
        if (!reset) begin
            if (eng.o_roi_vld) begin
                logTok.push_back(mk(4'd1, eng.o_ch, 32'(eng.o_roi)));
                logCyc.push_back(cyc);
            end
            if (eng.o_hit_vld) begin
                logTok.push_back(mk(4'd2, eng.o_ch, 32'(eng.o_hit)));
                logCyc.push_back(cyc);
            end
            if (eng.o_eof) begin
                logTok.push_back(mk(4'd3, eng.o_ch, 32'd0));
                logCyc.push_back(cyc);
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vecCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic expectTok(input string tag, input logic [39:0] expTok);
        if (logTok.size() > 0) begin
            lastTok = logTok.pop_front();
            lastCyc = logCyc.pop_front();
        end else begin
            lastTok = '1;
            lastCyc = -1;
        end
        checkOutput(tag, 64'(lastTok), 64'(expTok));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic applyStimulus(input logic [NCH-1:0] hitWe, input logic [NCH-1:0] eofV,
                                 input logic [NCH-1:0] roiWe, input logic [HIT_W-1:0] hitBase,
                                 input logic [ROI_W-1:0] roiBase);
        for (int c = 0; c < NCH; c++) begin
            mdt_hit[c] = hitBase + HIT_W'(c);
            roi[c]     = roiBase + ROI_W'(c);
        end
        mdt_hit_we = hitWe;
        i_eof      = eofV;
        roi_we     = roiWe;
        tick();
        mdt_hit_we = '0;
        i_eof      = '0;
        roi_we     = '0;
    endtask

    task automatic doReset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        logTok.delete();
        logCyc.delete();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_roi_vld"}, 64'(eng.o_roi_vld), 64'd0);
        checkOutput({tag, "_hit_vld"}, 64'(eng.o_hit_vld), 64'd0);
        checkOutput({tag, "_eof"},     64'(eng.o_eof),     64'd0);
        checkOutput({tag, "_data"},    {8'd0, eng.o_hit, eng.o_roi}, 64'd0);
        checkOutput({tag, "_ch"},      64'(eng.o_ch),      64'd0);
        checkOutput({tag, "_af"},      64'(o_hit_af),      64'd0);
        checkOutput({tag, "_hdrop"},   64'(o_hit_drop_cnt), 64'd0);
        checkOutput({tag, "_rdrop"},   64'(o_roi_drop_cnt), 64'd0);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int k;
        int h;
        int guard;
        reset              = 1'b1;
        mdt_hit            = '0;
        mdt_hit_we         = '0;
        roi                = '0;
        roi_we             = '0;
        i_eof              = '0;
        eng.i_engine_ready = 1'b1;
        tick();
        tick();
        checkIdleOutputs("rst");
        reset = 1'b0;
        tick();

        // Single event on ch0, ROI arriving after the hits.
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 24'hA, 32'h0);
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 24'hB, 32'h0);
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 24'h0, 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 24'h0, 32'h5);
        idle(20);
        expectTok("s1_roi",  mk(4'd1, 2'd0, 32'h5));
        expectTok("s1_hitA", mk(4'd2, 2'd0, 32'hA));
        expectTok("s1_hitB", mk(4'd2, 2'd0, 32'hB));
        expectTok("s1_eof",  mk(4'd3, 2'd0, 32'h0));
        checkOutput("s1_len", 64'(logTok.size()), 64'd0);

        // Latency: hit at t, eof at t+1 -> ROI t+3, hit t+4, eof t+5.
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 24'h0, 32'h6);
        k = cyc;
        applyStimulus(4'b0001, 4'b0000, 4'b0000, 24'h1, 32'h0);
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 24'h0, 32'h0);
        idle(12);
        expectTok("lat_roi", mk(4'd1, 2'd0, 32'h6));
        checkOutput("lat_roi_cyc", 64'(lastCyc), 64'(k + 3));
        expectTok("lat_hit", mk(4'd2, 2'd0, 32'h1));
        checkOutput("lat_hit_cyc", 64'(lastCyc), 64'(k + 4));
        expectTok("lat_eof", mk(4'd3, 2'd0, 32'h0));
        checkOutput("lat_eof_cyc", 64'(lastCyc), 64'(k + 5));

        // Round robin from reset: all four channels queued together.
        doReset();
        applyStimulus(4'b0000, 4'b0000, 4'b1111, 24'h0, 32'h10);
        applyStimulus(4'b1111, 4'b1111, 4'b0000, 24'h100, 32'h0);
        idle(20);
        for (int c = 0; c < NCH; c++) begin
            expectTok("s2_roi", mk(4'd1, 2'(c), 32'h10 + 32'(c)));
            expectTok("s2_hit", mk(4'd2, 2'(c), 32'h100 + 32'(c)));
            h = lastCyc;
            expectTok("s2_eof", mk(4'd3, 2'(c), 32'h0));
            checkOutput("s2_eof_same_cyc", 64'(lastCyc), 64'(h));
        end
        checkOutput("s2_len", 64'(logTok.size()), 64'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b1010, 24'h0, 32'h20);
        applyStimulus(4'b1000, 4'b0010, 4'b0000, 24'h30, 32'h0);
        applyStimulus(4'b0000, 4'b1000, 4'b0000, 24'h0, 32'h0);
        idle(20);
        expectTok("s2b_roi1", mk(4'd1, 2'd1, 32'h21));
        expectTok("s2b_eof1", mk(4'd3, 2'd1, 32'h0));
        expectTok("s2b_roi3", mk(4'd1, 2'd3, 32'h23));
        expectTok("s2b_hit3", mk(4'd2, 2'd3, 32'h33));
        expectTok("s2b_eof3", mk(4'd3, 2'd3, 32'h0));
        checkOutput("s2b_len", 64'(logTok.size()), 64'd0);

        // Overflow: 40 hits into a 32-deep FIFO on ch2, then eof and ROI.
        doReset();
        for (int i = 0; i < 40; i++) begin
            applyStimulus(4'b0100, 4'b0000, 4'b0000, 24'h200 + 24'(i), 32'h0);
        end
        checkOutput("s3_drop_wr", 64'(o_hit_drop_cnt[2]), 64'd9);
        checkOutput("s3_af",      64'(o_hit_af),          64'h4);
        applyStimulus(4'b0000, 4'b0100, 4'b0000, 24'h0, 32'h0);
        applyStimulus(4'b0000, 4'b0000, 4'b0100, 24'h0, 32'h5);
        idle(50);
        expectTok("s3_roi", mk(4'd1, 2'd2, 32'h7));
        for (int i = 0; i < 16; i++) begin
            expectTok("s3_hit", mk(4'd2, 2'd2, 32'h202 + 32'(i)));
        end
        expectTok("s3_eof", mk(4'd3, 2'd2, 32'h0));
        checkOutput("s3_len",      64'(logTok.size()),     64'd0);
        checkOutput("s3_drop_all", 64'(o_hit_drop_cnt),    64'h0000_0018_0000_0000);
        checkOutput("s3_af_clr",   64'(o_hit_af),          64'd0);

        // Backpressure and ROI FIFO overflow on ch3.
        doReset();
        eng.i_engine_ready = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 4'b0111, 24'h0, 32'h40);
        applyStimulus(4'b0000, 4'b0111, 4'b0000, 24'h0, 32'h0);
        repeat (5) applyStimulus(4'b0000, 4'b0000, 4'b1000, 24'h0, 32'h50);
        idle(5);
        checkOutput("s4_quiet",   64'(logTok.size()),  64'd0);
        checkOutput("s4_roidrop", 64'(o_roi_drop_cnt), 64'h0001_0000_0000_0000);
        eng.i_engine_ready = 1'b1;
        idle(20);
        for (int c = 0; c < 3; c++) begin
            expectTok("s4_roi", mk(4'd1, 2'(c), 32'h40 + 32'(c)));
            expectTok("s4_eof", mk(4'd3, 2'(c), 32'h0));
        end
        checkOutput("s4_len", 64'(logTok.size()), 64'd0);

        // Reset in the middle of an event, then a fresh event.
        doReset();
        applyStimulus(4'b0000, 4'b0000, 4'b0001, 24'h0, 32'h9);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(4'b0001, 4'b0000, 4'b0000, 24'h60 + 24'(i), 32'h0);
        end
        applyStimulus(4'b0000, 4'b0001, 4'b0000, 24'h0, 32'h0);
        guard = 0;
        while (!eng.o_hit_vld && guard < 50) begin
            tick();
            guard++;
        end
        checkOutput("s5_in_hits", 64'(eng.o_hit_vld), 64'd1);
        reset = 1'b1;
        tick();
        checkIdleOutputs("s5_rst");
        tick();
        reset = 1'b0;
        logTok.delete();
        logCyc.delete();
        idle(15);
        checkOutput("s5_no_eof", 64'(logTok.size()), 64'd0);
        applyStimulus(4'b0000, 4'b0000, 4'b0010, 24'h0, 32'h3B);
        applyStimulus(4'b0010, 4'b0000, 4'b0000, 24'h76, 32'h0);
        applyStimulus(4'b0000, 4'b0010, 4'b0000, 24'h0, 32'h0);
        idle(12);
        expectTok("s5_roi", mk(4'd1, 2'd1, 32'h3C));
        expectTok("s5_hit", mk(4'd2, 2'd1, 32'h77));
        expectTok("s5_eof", mk(4'd3, 2'd1, 32'h0));
        checkOutput("s5_len", 64'(logTok.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
        $finish;
    end
endmodule
